// File: rtl/reg_mem.sv
// Flip-flop register file, 2^ADDR_BITS x DATA_WIDTH, async-reset to zero; write takes 1 edge, no backpressure.
// Read is combinational by default; define REG_MEM_REG_OUT_EN for a registered read-before-write output (1 edge).
module reg_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wen) begin
      mem[addr] <= data_in;
    end
  end

`ifdef REG_MEM_REG_OUT_EN
  // Samples the pre-edge word, so a same-address write appears one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      data_out <= mem[addr];
    end
  end
`else
  assign data_out = mem[addr];
`endif

endmodule

// File: tb/tb_reg_mem.sv
// Randomised bench for reg_mem (default combinational-read build) against an array reference model.
module tb_reg_mem;

  logic [4:0] addr;
  logic [7:0] data_in;
  logic       wen;
  logic       clk;
  logic [7:0] data_out;
  logic       rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [32];

  reg_mem #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .addr     (addr),
    .data_in  (data_in),
    .wen      (wen),
    .clk      (clk),
    .data_out (data_out),
    .rst      (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
  endtask

  // One clock: drive at the falling edge, check the old word before the rising edge and the new word after it.
  task automatic do_cycle(input logic [4:0] a, input logic [7:0] d, input logic w, input string tag);
    @(negedge clk);
    addr = a;
    data_in = d;
    wen = w;
    #1;
    check({tag, "_pre"}, data_out, model[a]);
    @(posedge clk);
    if (w && !rst) model[a] = d;
    #1;
    check({tag, "_post"}, data_out, model[a]);
  endtask

  task automatic rd(input logic [4:0] a, input string tag);
    @(negedge clk);
    wen = 1'b0;
    addr = a;
    #1;
    check(tag, data_out, model[a]);
  endtask

  initial begin
    addr = '0;
    data_in = '0;
    wen = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    clear_model();

    // Reset state across the whole array, while reset is held and after release.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) rd(5'(i), "reset_hold");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) rd(5'(i), "reset_released");

    // Sequential fill 10..17 into 12..19.
    for (int i = 0; i < 8; i++) do_cycle(5'(12 + i), 8'(10 + i), 1'b1, "fill");
    for (int i = 0; i < 8; i++) begin
      rd(5'(12 + i), "fill_read");
      check("fill_value", data_out, 8'(10 + i));
    end
    rd(5'd0, "untouched_0");
    check("untouched_0_zero", data_out, 8'h00);
    rd(5'd11, "untouched_11");
    rd(5'd20, "untouched_20");

    // Write inhibit.
    repeat (4) do_cycle(5'd12, 8'hAA, 1'b0, "inhibit");
    check("inhibit_value", data_out, 8'd10);

    // Address boundaries.
    do_cycle(5'd0, 8'hFF, 1'b1, "bound_lo");
    do_cycle(5'd31, 8'h5A, 1'b1, "bound_hi");
    rd(5'd0, "bound_lo_read");
    check("bound_lo_value", data_out, 8'hFF);
    rd(5'd31, "bound_hi_read");
    check("bound_hi_value", data_out, 8'h5A);
    rd(5'd1, "bound_1");
    rd(5'd30, "bound_30");

    // Reset asserted between edges with a write pending: every word clears and the write is ignored.
    @(negedge clk);
    addr = 5'd15;
    data_in = 8'h33;
    wen = 1'b1;
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    check("midrst_async", data_out, 8'h00);
    for (int i = 0; i < 32; i++) do_cycle(5'(i), 8'h33, 1'b1, "midrst_sweep");
    @(negedge clk);
    wen = 1'b0;
    #2;
    rst = 1'b0;
    do_cycle(5'd15, 8'h33, 1'b1, "after_rst_write");
    check("after_rst_value", data_out, 8'h33);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      do_cycle(5'($urandom_range(0, 31)), 8'($urandom), ($urandom_range(0, 2) != 0), "random");
    end
    for (int i = 0; i < 32; i++) rd(5'(i), "final_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
